// File: rtl/if_prefetch.sv
// -----------------------------------------------------------------------------
// if_prefetch
//   Instruction prefetch buffer that sits between an instruction memory and
//   the core IF stage. It issues sequential word fetches, keeps up to
//   MAX_OUTST requests in flight, and queues returned instructions (with
//   their addresses) in a DEPTH-entry FIFO. A flush redirects fetching and
//   silently drops responses to requests issued before the redirect.
//
// Parameters
//   DEPTH      FIFO entries (power of two, 2..8)
//   MAX_OUTST  maximum memory requests in flight (1..DEPTH)
//   RESET_PC   first fetch address after reset
//
// Ports
//   clk, rst               clock; asynchronous active-low reset
//   mem_req_o/mem_addr_o   fetch request and word-aligned address
//   mem_gnt_i              memory accepts the request this cycle
//   mem_rvalid_i/rdata_i   in-order read response
//   inst_valid_o/ready_i   FIFO head handshake towards the core
//   inst_o/inst_addr_o     head instruction/address (NOP/0 when empty)
//   flush_i/flush_addr_i   redirect request and target
// -----------------------------------------------------------------------------
module if_prefetch #(
    parameter int          DEPTH     = 4,
    parameter int          MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    input  logic        flush_i,
    input  logic [31:0] flush_addr_i
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;  // pointer width
    localparam int CW = PW + 1;                           // counts 0..DEPTH
    localparam logic [CW:0]   DEPTH_S = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] MAX_S   = CW'(MAX_OUTST);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    logic          run_reg;
    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [31:0]   resp_pc_reg, resp_pc_next;
    logic [CW-1:0] count_reg, count_next;
    logic [CW-1:0] outst_reg, outst_next;
    logic [CW-1:0] discard_reg, discard_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;

    logic          has_rsp;
    logic          room;
    logic          fire;
    logic          drop;
    logic          push;
    logic          pop;
    logic [31:0]   flush_target;
    logic [63:0]   entry [DEPTH];
    logic [63:0]   head;

    // Masking (rather than slicing) keeps every flush_addr_i bit in use.
    assign flush_target = flush_addr_i & 32'hFFFF_FFFC;

    // A response only counts when something is actually in flight.
    assign has_rsp = mem_rvalid_i && (outst_reg != '0);

    // Every issued request reserves a FIFO slot, so a push can never overflow.
    assign room = ({1'b0, count_reg} + {1'b0, outst_reg}) < DEPTH_S;

    // run_reg holds the request off until the first edge after reset release.
    assign mem_req_o  = run_reg && !flush_i && (outst_reg < MAX_S) && room;
    assign mem_addr_o = fetch_pc_reg;
    assign fire       = mem_req_o && mem_gnt_i;

    assign drop = has_rsp && (discard_reg != '0);
    assign push = has_rsp && (discard_reg == '0) && !flush_i;
    assign pop  = inst_valid_o && inst_ready_i && !flush_i;

    // FIFO storage: one register per entry, written at the write pointer.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [63:0] entry_reg;
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_reg == PW'(gi))) begin
                entry_reg <= {resp_pc_reg, mem_rdata_i};
            end
        end
        assign entry[gi] = entry_reg;
    end

    assign head         = entry[rd_ptr_reg];
    assign inst_valid_o = (count_reg != '0);
    assign inst_o       = inst_valid_o ? head[31:0]  : NOP;
    assign inst_addr_o  = inst_valid_o ? head[63:32] : 32'h0;

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        resp_pc_next  = resp_pc_reg;
        count_next    = count_reg + CW'(push) - CW'(pop);
        outst_next    = outst_reg + CW'(fire) - CW'(has_rsp);
        discard_next  = discard_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;

        if (fire) begin
            fetch_pc_next = fetch_pc_reg + 32'd4;
        end
        if (drop) begin
            discard_next = discard_reg - CW'(1);
        end
        if (push) begin
            wr_ptr_next  = wr_ptr_reg + PW'(1);
            resp_pc_next = resp_pc_reg + 32'd4;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PW'(1);
        end

        // Redirect: everything still in flight after this cycle belongs to
        // the old stream and must be thrown away when it returns.
        if (flush_i) begin
            fetch_pc_next = flush_target;
            resp_pc_next  = flush_target;
            count_next    = '0;
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            discard_next  = outst_reg - CW'(has_rsp);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_reg      <= 1'b0;
            fetch_pc_reg <= RESET_PC;
            resp_pc_reg  <= RESET_PC;
            count_reg    <= '0;
            outst_reg    <= '0;
            discard_reg  <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            run_reg      <= 1'b1;
            fetch_pc_reg <= fetch_pc_next;
            resp_pc_reg  <= resp_pc_next;
            count_reg    <= count_next;
            outst_reg    <= outst_next;
            discard_reg  <= discard_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
// -----------------------------------------------------------------------------
// tb_if_prefetch
//   Self-checking bench for if_prefetch (DEPTH=4, MAX_OUTST=2, RESET_PC=0).
//   A directed vector table, a few hand-written multi-cycle sequences and a
//   randomized run compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_if_prefetch;

    localparam int          DEPTH     = 4;
    localparam int          MAX_OUTST = 2;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic        H = 1'b1;
    localparam logic        L = 1'b0;

    logic        clk;
    logic        rst;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        flush_i;
    logic [31:0] flush_addr_i;

    if_prefetch #(
        .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o),
        .flush_i(flush_i), .flush_addr_i(flush_addr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // ---------------- reference model and memory ----------------
    typedef struct { logic [31:0] addr; bit stale; } infl_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } ent_t;
    typedef struct { logic [31:0] addr; int cyc; } memq_t;

    infl_t       m_infl[$];
    ent_t        m_fifo[$];
    memq_t       memq[$];
    logic [31:0] m_fetch;
    bit          m_run;

    logic        obs_req, obs_valid;
    logic [31:0] obs_addr, obs_inst, obs_iaddr;

    // One clock cycle: compare outputs at the falling edge against the model,
    // advance the model and the memory, then return just after the rising edge.
    task automatic step();
        logic        e_req;
        logic [31:0] e_inst, e_iaddr;
        bit          rv, pop, fire;
        infl_t       e;
        @(negedge clk);
        obs_req = mem_req_o;  obs_addr = mem_addr_o;  obs_valid = inst_valid_o;
        obs_inst = inst_o;    obs_iaddr = inst_addr_o;
        e_req   = m_run && !flush_i && (m_infl.size() < MAX_OUTST)
                  && (m_fifo.size() + m_infl.size() < DEPTH);
        e_inst  = (m_fifo.size() > 0) ? m_fifo[0].data : NOP;
        e_iaddr = (m_fifo.size() > 0) ? m_fifo[0].addr : 32'h0;
        chk1 ($sformatf("req@%0d", cyc),   mem_req_o,    e_req);
        chk32($sformatf("addr@%0d", cyc),  mem_addr_o,   m_fetch);
        chk1 ($sformatf("valid@%0d", cyc), inst_valid_o, m_fifo.size() > 0);
        chk32($sformatf("inst@%0d", cyc),  inst_o,       e_inst);
        chk32($sformatf("iaddr@%0d", cyc), inst_addr_o,  e_iaddr);

        rv   = mem_rvalid_i && (m_infl.size() > 0);
        pop  = !flush_i && (m_fifo.size() > 0) && inst_ready_i;
        fire = e_req && mem_gnt_i;
        if (pop) void'(m_fifo.pop_front());
        if (rv) begin
            e = m_infl.pop_front();
            if (!e.stale && !flush_i) m_fifo.push_back('{addr: e.addr, data: mem_rdata_i});
        end
        if (flush_i) begin
            m_fifo.delete();
            foreach (m_infl[k]) m_infl[k].stale = 1'b1;
            m_fetch = flush_addr_i & 32'hFFFF_FFFC;
        end
        if (fire) begin
            m_infl.push_back('{addr: m_fetch, stale: 1'b0});
            m_fetch = m_fetch + 32'd4;
        end
        m_run = 1'b1;

        if (mem_req_o && mem_gnt_i) memq.push_back('{addr: mem_addr_o, cyc: cyc});
        if (mem_rvalid_i && memq.size() > 0) void'(memq.pop_front());
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Memory behaviour: random grant; in-order response at least one cycle
    // after its grant; optional spurious rvalid while nothing is pending.
    task automatic drive_mem(int gnt_pct, int rv_pct, int spur_pct);
        mem_gnt_i    = (int'($urandom_range(99)) < gnt_pct);
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom;
        if (memq.size() > 0 && memq[0].cyc < cyc && int'($urandom_range(99)) < rv_pct) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = mem_word(memq[0].addr);
        end else if (memq.size() == 0 && int'($urandom_range(99)) < spur_pct) begin
            mem_rvalid_i = 1'b1;
        end
    endtask

    // Holds reset for two edges and releases it just after a rising edge;
    // the memory and the model restart together with the DUT.
    task automatic do_reset();
        rst = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        inst_ready_i = 1'b0; flush_i = 1'b0; flush_addr_i = 32'h0;
        memq.delete(); m_infl.delete(); m_fifo.delete();
        m_fetch = RESET_PC; m_run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic gnt; logic rv; logic [31:0] rdata; logic ready; logic flush; logic [31:0] faddr;
        logic e_req; logic [31:0] e_addr; logic e_valid; logic [31:0] e_inst; logic [31:0] e_iaddr;
    } vec_t;
    vec_t tbl[28];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] nxt;
        bit          seen;

        //            gnt rv rdata          rdy flush faddr        req addr          vld inst           iaddr
        tbl[0]  = '{H, L, 32'h0,         H, L, 32'h0,   H, 32'h000, L, NOP,           32'h0};
        tbl[1]  = '{H, H, 32'hD000_0000, H, L, 32'h0,   H, 32'h004, L, NOP,           32'h0};
        tbl[2]  = '{L, H, 32'hD000_0004, H, L, 32'h0,   H, 32'h008, H, 32'hD000_0000, 32'h0};
        tbl[3]  = '{L, L, 32'h0,         H, L, 32'h0,   H, 32'h008, H, 32'hD000_0004, 32'h4};
        tbl[4]  = '{L, L, 32'h0,         H, L, 32'h0,   H, 32'h008, L, NOP,           32'h0};
        tbl[5]  = '{H, L, 32'h0,         H, L, 32'h0,   H, 32'h008, L, NOP,           32'h0};
        tbl[6]  = '{H, L, 32'h0,         H, L, 32'h0,   H, 32'h00C, L, NOP,           32'h0};
        tbl[7]  = '{H, L, 32'h0,         H, H, 32'h102, L, 32'h010, L, NOP,           32'h0};
        tbl[8]  = '{H, H, 32'hBAD0_0001, H, L, 32'h0,   L, 32'h100, L, NOP,           32'h0};
        tbl[9]  = '{H, H, 32'hBAD0_0002, H, L, 32'h0,   H, 32'h100, L, NOP,           32'h0};
        tbl[10] = '{H, H, 32'hE000_0100, H, L, 32'h0,   H, 32'h104, L, NOP,           32'h0};
        tbl[11] = '{L, H, 32'hE000_0104, H, L, 32'h0,   H, 32'h108, H, 32'hE000_0100, 32'h100};
        tbl[12] = '{L, L, 32'h0,         L, L, 32'h0,   H, 32'h108, H, 32'hE000_0104, 32'h104};
        tbl[13] = '{L, H, 32'hDEAD_BEEF, L, L, 32'h0,   H, 32'h108, H, 32'hE000_0104, 32'h104};
        tbl[14] = '{L, L, 32'h0,         H, L, 32'h0,   H, 32'h108, H, 32'hE000_0104, 32'h104};
        tbl[15] = '{L, L, 32'h0,         H, L, 32'h0,   H, 32'h108, L, NOP,           32'h0};
        tbl[16] = '{H, L, 32'h0,         H, L, 32'h0,   H, 32'h108, L, NOP,           32'h0};
        tbl[17] = '{H, L, 32'h0,         H, L, 32'h0,   H, 32'h10C, L, NOP,           32'h0};
        tbl[18] = '{L, H, 32'hD000_0108, L, L, 32'h0,   L, 32'h110, L, NOP,           32'h0};
        tbl[19] = '{H, L, 32'h0,         L, L, 32'h0,   H, 32'h110, H, 32'hD000_0108, 32'h108};
        tbl[20] = '{H, H, 32'hD000_010C, H, H, 32'h203, L, 32'h114, H, 32'hD000_0108, 32'h108};
        tbl[21] = '{H, H, 32'hD000_0110, H, L, 32'h0,   H, 32'h200, L, NOP,           32'h0};
        tbl[22] = '{L, H, 32'hE000_0200, H, L, 32'h0,   H, 32'h204, L, NOP,           32'h0};
        tbl[23] = '{L, L, 32'h0,         H, L, 32'h0,   H, 32'h204, H, 32'hE000_0200, 32'h200};
        tbl[24] = '{L, L, 32'h0,         H, L, 32'h0,   H, 32'h204, L, NOP,           32'h0};
        tbl[25] = '{H, L, 32'h0,         H, H, 32'h300, L, 32'h204, L, NOP,           32'h0};
        tbl[26] = '{H, L, 32'h0,         H, H, 32'h404, L, 32'h300, L, NOP,           32'h0};
        tbl[27] = '{H, L, 32'h0,         H, L, 32'h0,   H, 32'h404, L, NOP,           32'h0};

        // Reset values while reset is held, then no request before the first edge.
        rst = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        inst_ready_i = 1'b0; flush_i = 1'b0; flush_addr_i = 32'h0;
        #3;
        chk1 ("rst_req",   mem_req_o,    1'b0);
        chk1 ("rst_valid", inst_valid_o, 1'b0);
        chk32("rst_inst",  inst_o,       NOP);
        chk32("rst_iaddr", inst_addr_o,  32'h0);
        do_reset();
        chk1 ("release_req", mem_req_o, 1'b0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 28; i++) begin
            mem_gnt_i = tbl[i].gnt;  mem_rvalid_i = tbl[i].rv;  mem_rdata_i = tbl[i].rdata;
            inst_ready_i = tbl[i].ready;  flush_i = tbl[i].flush;  flush_addr_i = tbl[i].faddr;
            @(negedge clk);
            chk1 ($sformatf("row%0d_req", i),   mem_req_o,    tbl[i].e_req);
            chk32($sformatf("row%0d_addr", i),  mem_addr_o,   tbl[i].e_addr);
            chk1 ($sformatf("row%0d_valid", i), inst_valid_o, tbl[i].e_valid);
            chk32($sformatf("row%0d_inst", i),  inst_o,       tbl[i].e_inst);
            chk32($sformatf("row%0d_iaddr", i), inst_addr_o,  tbl[i].e_iaddr);
            @(posedge clk);
            #1;
        end

        // Streaming: grant always, one-cycle response, core always ready.
        do_reset();
        nxt = RESET_PC; seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive_mem(100, 100, 0);
            inst_ready_i = 1'b1;
            step();
            if (i == 1) begin
                chk1 ("first_req",  obs_req,  1'b1);
                chk32("first_addr", obs_addr, RESET_PC);
            end
            if (obs_valid) seen = 1'b1;
            if (seen) begin
                chk1 ("stream_valid", obs_valid, 1'b1);
                chk32("stream_iaddr", obs_iaddr, nxt);
                chk32("stream_inst",  obs_inst,  mem_word(nxt));
                nxt = nxt + 32'd4;
            end
        end
        chk1("stream_started", seen, 1'b1);

        // Backpressure: core holds for 10 cycles, then drains with no new grants.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive_mem(100, 100, 0);
            inst_ready_i = 1'b0;
            step();
        end
        chk1("bp_req_low", obs_req,   1'b0);
        chk1("bp_valid",   obs_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive_mem(0, 100, 0);
            inst_ready_i = 1'b1;
            step();
            chk1("bp_drain_valid", obs_valid, (i < 4));
            if (i < 4) chk32("bp_drain_iaddr", obs_iaddr, 32'(i * 4));
        end

        // Grant stall: two grants, then three cycles of gnt low with req high.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive_mem((i == 1 || i == 2 || i > 5) ? 100 : 0, 100, 0);
            inst_ready_i = 1'b1;
            step();
            if (i >= 3 && i <= 5) begin
                chk1 ("stall_req",  obs_req,  1'b1);
                chk32("stall_addr", obs_addr, 32'h8);
            end
        end

        // Reset mid-operation, asserted between clock edges.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_mem(100, 50, 0);
            inst_ready_i = 1'b0;
            step();
        end
        chk1("pre_reset_valid", obs_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk1 ("async_rst_req",   mem_req_o,    1'b0);
        chk1 ("async_rst_valid", inst_valid_o, 1'b0);
        chk32("async_rst_inst",  inst_o,       NOP);
        chk32("async_rst_iaddr", inst_addr_o,  32'h0);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_mem(100, 100, 0);
            inst_ready_i = 1'b1;
            step();
            if (i == 1) chk32("refetch_addr", obs_addr, RESET_PC);
        end

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive_mem(70, 60, 5);
            inst_ready_i = (int'($urandom_range(99)) < 70);
            flush_i      = (int'($urandom_range(99)) < 3);
            flush_addr_i = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
